bellek_ram_clr: RTL and testbench

//  Parametrised single-port synchronous RAM with byte enables and selectable write/read mode.

---
 rtl/bellek_ram_clr.sv | 133 +++++++++++++
 tb/tb_bellek_ram_clr.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bellek_ram_clr.sv
// Single-port byte-enabled RAM with a clear engine that zeroes the array after reset or on a clr pulse.
// Latency: read (and WRITE_FIRST write) data appears 1 cycle after the access, 2 with OUT_REG=1.
// Backpressure: none on q; accesses presented while busy=1 (or together with clr) are silently dropped.
module bellek_ram_clr #(
  parameter int          DW      = 32,
  parameter int          AW      = 8,
  parameter int          DEPTH   = 256,
  parameter bit          OUT_REG = 1'b0,
  parameter bit          WR_MODE = 1'b0,
  parameter logic [DW-1:0] CLR_VAL = {DW{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   a,
  input  logic [DW-1:0]   d,
  input  logic            clr,
  output logic [DW-1:0]   q,
  output logic            q_valid,
  output logic            busy
);

  localparam int NB = DW / 8;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_X  = (AW + 1)'(DEPTH);

  logic [0:0]    state;
  logic [AW-1:0] ptr;
  logic [DW-1:0] mem [DEPTH];

  logic          in_range;
  logic          acc;
  logic          issue;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] mrg_word;

  logic          r1_vld;
  logic [DW-1:0] r1_dat;

  assign busy     = (state == ST_CLEAR);
  assign in_range = ({1'b0, a} < DEPTH_X);
  // clr wins over a same-cycle access; reset also kills the access in its cycle
  assign acc      = !rst && (state == ST_IDLE) && en && !clr;
  // NO_CHANGE writes produce no result; WRITE_FIRST writes behave like reads on the output side
  assign issue    = acc && (!we || WR_MODE);

  // Current word at a and the byte-merged word a write would store (zero outside the array)
  always_comb begin
    rd_word  = '0;
    mrg_word = '0;
    if (in_range) begin
      rd_word  = mem[a];
      mrg_word = mem[a];
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mrg_word[8*i +: 8] = d[8*i +: 8];
      end
    end
  end

  // Control FSM: reset or an idle clr starts a full sweep from address 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == PTR_LAST) state <= ST_IDLE;
        end
        default: begin
          if (clr) begin
            state <= ST_CLEAR;
            ptr   <= '0;
          end
        end
      endcase
    end
  end

  // Array update: clear sweep has exclusive use of the port while busy
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[ptr] <= CLR_VAL;
    end else if (acc && we && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[a][8*i +: 8] <= d[8*i +: 8];
      end
    end
  end

  // First output stage: data only updates on a result, so q holds between pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_vld <= 1'b0;
      r1_dat <= '0;
    end else begin
      r1_vld <= issue;
      if (issue) r1_dat <= we ? mrg_word : rd_word;
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic          r2_vld;
      logic [DW-1:0] r2_dat;

      // Optional second stage; keeps draining independently of the clear engine
      always_ff @(posedge clk) begin
        if (rst) begin
          r2_vld <= 1'b0;
          r2_dat <= '0;
        end else begin
          r2_vld <= r1_vld;
          if (r1_vld) r2_dat <= r1_dat;
        end
      end

      assign q       = r2_dat;
      assign q_valid = r2_vld;
    end else begin : g_no_out_reg
      assign q       = r1_dat;
      assign q_valid = r1_vld;
    end
  endgenerate

endmodule

// File: tb/tb_bellek_ram_clr.sv
// Bench for bellek_ram_clr: two instances share stimulus (NO_CHANGE/latency 1 and WRITE_FIRST/latency 2).
// Expected results come from a shadow memory model and are queued per instance with their due cycle.
// Output checks run on the falling edge; test tasks add direct busy-length and data checks.
module tb_bellek_ram_clr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  be  = 4'h0;
  logic [7:0]  a   = 8'h00;
  logic [31:0] d   = 32'h0;
  logic        clr = 1'b0;

  logic [31:0] q0, q1;
  logic        q_valid0, q_valid1, busy0, busy1;

  always #5 clk = ~clk;

  bellek_ram_clr #(.DW(32), .AW(8), .DEPTH(256), .OUT_REG(1'b0), .WR_MODE(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .a(a), .d(d), .clr(clr),
    .q(q0), .q_valid(q_valid0), .busy(busy0)
  );

  bellek_ram_clr #(.DW(32), .AW(8), .DEPTH(256), .OUT_REG(1'b1), .WR_MODE(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .we(we), .be(be), .a(a), .d(d), .clr(clr),
    .q(q1), .q_valid(q_valid1), .busy(busy1)
  );

  typedef struct {
    logic [31:0] dat;
    int          due;
  } exp_t;

  exp_t        sb0[$];
  exp_t        sb1[$];
  exp_t        e0, e1;
  logic [31:0] mdl [256];
  logic        m_busy = 1'b0;
  int          m_ptr  = 0;
  logic [31:0] m_last0 = 32'h0;
  logic [31:0] m_last1 = 32'h0;
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Drive one cycle of stimulus, advance the model by the same cycle, then step past the edge.
  task automatic step(input logic r, input logic e, input logic w, input logic [3:0] b,
                      input logic [7:0] ad, input logic [31:0] dd, input logic c);
    logic        acc;
    logic [31:0] rd, mg;
    rst = r; en = e; we = w; be = b; a = ad; d = dd; clr = c;
    acc = !r && !m_busy && e && !c;
    if (acc) begin
      rd = mdl[ad];
      mg = rd;
      for (int i = 0; i < 4; i++) if (b[i]) mg[8*i +: 8] = dd[8*i +: 8];
      if (!w) sb0.push_back('{rd, cyc + 1});
      sb1.push_back('{(w ? mg : rd), cyc + 2});
      if (w) mdl[ad] = mg;
    end
    if (r) begin
      m_busy = 1'b1;
      m_ptr  = 0;
      sb0.delete();
      sb1.delete();
    end else if (m_busy) begin
      mdl[m_ptr] = 32'h0;
      if (m_ptr == 255) m_busy = 1'b0;
      m_ptr = m_ptr + 1;
    end else if (c) begin
      m_busy = 1'b1;
      m_ptr  = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
  endtask

  // Scoreboard: every q_valid pulse must match the oldest queued result at its due cycle
  always @(negedge clk) begin
    if (q_valid0 === 1'b1) begin
      checks = checks + 1;
      if (sb0.size() == 0) begin
        errors = errors + 1;
        $display("FAIL sb0_unexpected_valid cyc=%0d q=%h expected no result", cyc, q0);
      end else begin
        e0 = sb0.pop_front();
        if (q0 !== e0.dat || cyc != e0.due) begin
          errors = errors + 1;
          $display("FAIL sb0_result got q=%h at cyc %0d, want q=%h at cyc %0d", q0, cyc, e0.dat, e0.due);
        end
        m_last0 = e0.dat;
      end
    end else if (sb0.size() > 0 && sb0[0].due <= cyc) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL sb0_missing_valid cyc=%0d q_valid=%b want q=%h", cyc, q_valid0, sb0[0].dat);
      void'(sb0.pop_front());
    end

    if (q_valid1 === 1'b1) begin
      checks = checks + 1;
      if (sb1.size() == 0) begin
        errors = errors + 1;
        $display("FAIL sb1_unexpected_valid cyc=%0d q=%h expected no result", cyc, q1);
      end else begin
        e1 = sb1.pop_front();
        if (q1 !== e1.dat || cyc != e1.due) begin
          errors = errors + 1;
          $display("FAIL sb1_result got q=%h at cyc %0d, want q=%h at cyc %0d", q1, cyc, e1.dat, e1.due);
        end
        m_last1 = e1.dat;
      end
    end else if (sb1.size() > 0 && sb1[0].due <= cyc) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL sb1_missing_valid cyc=%0d q_valid=%b want q=%h", cyc, q_valid1, sb1[0].dat);
      void'(sb1.pop_front());
    end
  end

  // Clear after reset lasts 256 cycles with reads held on en; then a read of 5 returns zero
  task automatic test_reset();
    int n;
    step(1'b1, 1'b1, 1'b0, 4'h0, 8'h05, 32'h0, 1'b0);
    checks = checks + 1;
    if (q0 !== 32'h0 || q_valid0 !== 1'b0 || q1 !== 32'h0 || q_valid1 !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs q0=%h v0=%b q1=%h v1=%b want 0/0", q0, q_valid0, q1, q_valid1);
    end
    n = 0;
    while (busy0 === 1'b1 && n < 400) begin
      n = n + 1;
      step(1'b0, 1'b1, 1'b0, 4'h0, 8'h05, 32'h0, 1'b0);
    end
    checks = checks + 1;
    if (n != 256 || busy1 !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_busy_len got %0d cycles busy1=%b want 256 and 0", n, busy1);
    end
    step(1'b0, 1'b1, 1'b0, 4'h0, 8'h05, 32'h0, 1'b0);
    idle(3);
    checks = checks + 1;
    if (q0 !== 32'h0) begin
      errors = errors + 1;
      $display("FAIL reset_read5 got %h want 00000000", q0);
    end
  endtask

  // Full-word write then read; NO_CHANGE output must hold across the write
  task automatic test_write_read();
    step(1'b0, 1'b1, 1'b1, 4'hF, 8'h05, 32'hDEADBEEF, 1'b0);
    idle(1);
    checks = checks + 1;
    if (q0 !== m_last0) begin
      errors = errors + 1;
      $display("FAIL write_hold q0=%h want %h", q0, m_last0);
    end
    step(1'b0, 1'b1, 1'b0, 4'h0, 8'h05, 32'h0, 1'b0);
    idle(3);
    checks = checks + 1;
    if (q0 !== 32'hDEADBEEF || q1 !== 32'hDEADBEEF) begin
      errors = errors + 1;
      $display("FAIL write_read q0=%h q1=%h want deadbeef", q0, q1);
    end
  endtask

  // Partial write touches only byte 1
  task automatic test_byte_enable();
    step(1'b0, 1'b1, 1'b1, 4'b0010, 8'h05, 32'h0000AA00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 8'h05, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'h0, 8'h05, 32'h11111111, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 8'h05, 32'h0, 1'b0);
    idle(3);
    checks = checks + 1;
    if (q0 !== 32'hDEADAAEF) begin
      errors = errors + 1;
      $display("FAIL byte_enable q0=%h want deadaaef", q0);
    end
  endtask

  // clr beats a same-cycle write; a second clr mid-sweep does not restart it
  task automatic test_clr_priority();
    int n;
    step(1'b0, 1'b1, 1'b1, 4'hF, 8'h07, 32'h77777777, 1'b1);
    n = 0;
    while (busy0 === 1'b1 && n < 400) begin
      n = n + 1;
      step(1'b0, 1'b1, 1'b1, 4'hF, 8'h07, 32'h12121212, (n == 50));
    end
    checks = checks + 1;
    if (n != 256) begin
      errors = errors + 1;
      $display("FAIL clr_busy_len got %0d want 256", n);
    end
    step(1'b0, 1'b1, 1'b0, 4'h0, 8'h05, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 8'h07, 32'h0, 1'b0);
    idle(3);
    checks = checks + 1;
    if (q0 !== 32'h0 || q1 !== 32'h0) begin
      errors = errors + 1;
      $display("FAIL clr_dropped_write q0=%h q1=%h want 0", q0, q1);
    end
  endtask

  // Reset in the middle of a sweep restarts it; write during busy is lost
  task automatic test_rst_mid_clear();
    int n;
    step(1'b0, 1'b1, 1'b1, 4'hF, 8'h02, 32'hCAFEF00D, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 8'h02, 32'h0, 1'b0);
    idle(3);
    checks = checks + 1;
    if (q0 !== 32'hCAFEF00D) begin
      errors = errors + 1;
      $display("FAIL rst_mid_prewrite q0=%h want cafef00d", q0);
    end
    step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1);
    idle(99);
    step(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
    n = 0;
    while (busy0 === 1'b1 && n < 400) begin
      n = n + 1;
      if (n == 1) step(1'b0, 1'b1, 1'b1, 4'hF, 8'h02, 32'h5A5A5A5A, 1'b0);
      else        step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
    end
    checks = checks + 1;
    if (n != 256) begin
      errors = errors + 1;
      $display("FAIL rst_mid_busy_len got %0d want 256", n);
    end
    step(1'b0, 1'b1, 1'b0, 4'h0, 8'h02, 32'h0, 1'b0);
    idle(3);
    checks = checks + 1;
    if (q0 !== 32'h0 || q1 !== 32'h0) begin
      errors = errors + 1;
      $display("FAIL rst_mid_read2 q0=%h q1=%h want 0", q0, q1);
    end
  endtask

  // Write then immediate read of the same word, followed by a burst of reads, one per cycle
  task automatic test_back_to_back();
    step(1'b0, 1'b1, 1'b1, 4'hF, 8'h03, 32'h12345678, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 8'h03, 32'h0, 1'b0);
    idle(3);
    checks = checks + 1;
    if (q1 !== 32'h12345678 || q0 !== 32'h12345678) begin
      errors = errors + 1;
      $display("FAIL b2b_write_first q1=%h q0=%h want 12345678", q1, q0);
    end
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b1, 4'hF, 8'(8'h40 + i), 32'hA0000000 | i, 1'b0);
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b0, 4'h0, 8'(8'h47 - i), 32'h0, 1'b0);
    idle(3);
    checks = checks + 1;
    if (q0 !== 32'hA0000000 || q1 !== 32'hA0000000) begin
      errors = errors + 1;
      $display("FAIL b2b_last_read q0=%h q1=%h want a0000000", q0, q1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = 32'h0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_clr_priority();
    test_rst_mid_clear();
    test_back_to_back();
    idle(4);
    checks = checks + 1;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain pending sb0=%0d sb1=%0d want 0", sb0.size(), sb1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
